// File: rtl/seg_scan_encoder.sv
// Scan-slot digit picker + 7-seg encoder feeding the 595 serializer; out_valid 2 clk after tick,
// word held until out_ready, lost ticks set sticky overrun. SEG_SCAN_LZB_EN adds leading-zero blanking.
module seg_scan_encoder #(
  parameter int NUM_DIG  = 6,
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NUM_DIG-1:0] value,
  input  logic [NUM_DIG-1:0]   dp_mask,
  input  logic                 enable,
  output logic [15:0]          out_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_start,
  output logic                 overrun
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [2:0] LAST_DIG = 3'(NUM_DIG - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] seg;
  } word_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        scan_cnt;
  logic                 tick;
  logic [2:0]           digit_idx;
  logic [4*NUM_DIG-1:0] sh_value;
  logic [NUM_DIG-1:0]   sh_dp;
  logic                 sh_en;
  logic [4*NUM_DIG-1:0] src_value;
  logic [NUM_DIG-1:0]   src_dp;
  logic                 src_en;
  logic [3:0]           nibble;
  logic                 dp_on;
  word_t                word_nxt;
  logic                 accept;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign tick        = (scan_cnt == CW'(SCAN_DIV - 1));
  assign out_valid   = (state == PRESENT);
  assign accept      = out_valid & out_ready;
  assign frame_start = accept & (digit_idx == 3'd0);

  // Digit 0 encodes straight from the live inputs, the same values being latched as the frame snapshot.
  assign src_value = (digit_idx == 3'd0) ? value   : sh_value;
  assign src_dp    = (digit_idx == 3'd0) ? dp_mask : sh_dp;
  assign src_en    = (digit_idx == 3'd0) ? enable  : sh_en;

  always_comb begin
    nibble = 4'h0;
    dp_on  = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (digit_idx == 3'(i)) begin
        nibble = src_value[4*i +: 4];
        dp_on  = src_dp[i];
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic blank;
  always_comb begin
    blank = 1'b0;
    for (int i = 1; i < NUM_DIG; i++) begin
      if (digit_idx == 3'(i)) blank = ((src_value >> (4*i)) == '0);
    end
  end
`endif

  always_comb begin
    word_nxt.seg = {~dp_on, seg7(nibble)};
`ifdef SEG_SCAN_LZB_EN
    if (blank) word_nxt.seg[6:0] = 7'h7F;
`endif
    word_nxt.sel = ~(8'd1 << digit_idx);
    if (!src_en) word_nxt = 16'hFFFF;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = LOAD;
      LOAD:    state_nxt = PRESENT;
      PRESENT: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 3'd0;
      sh_value  <= '0;
      sh_dp     <= '0;
      sh_en     <= 1'b0;
      out_word  <= 16'hFFFF;
      overrun   <= 1'b0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + CW'(1);
      if (tick && state != IDLE) overrun <= 1'b1;
      if (state == LOAD) begin
        if (digit_idx == 3'd0) begin
          sh_value <= value;
          sh_dp    <= dp_mask;
          sh_en    <= enable;
        end
        out_word <= word_nxt;
      end
      if (accept) digit_idx <= (digit_idx == LAST_DIG) ? 3'd0 : digit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_seg_scan_encoder.sv
// Directed + randomized bench for seg_scan_encoder (NUM_DIG=6, SCAN_DIV=8) against a rule-level display model.
module tb_seg_scan_encoder;

  localparam int ND = 6;
  localparam int SD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] value;
  logic [5:0]  dp_mask;
  logic        enable;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        frame_start;
  logic        overrun;

  seg_scan_encoder #(.NUM_DIG(ND), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_mask(dp_mask), .enable(enable),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .frame_start(frame_start), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // inputs as seen at the most recent rising edge
  logic [23:0] lv_value;
  logic [5:0]  lv_dp;
  logic        lv_en;
  always @(posedge clk) begin
    lv_value <= value;
    lv_dp    <= dp_mask;
    lv_en    <= enable;
  end

  // model state: next digit expected, frame snapshot, expected overrun
  int          m_idx = 0;
  logic [23:0] s_val;
  logic [5:0]  s_dp;
  logic        s_en;
  logic        m_ovr = 1'b0;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [15:0] model(input logic [23:0] v, input logic [5:0] dp,
                                        input logic en, input int idx);
    logic [7:0] seg, sel;
    logic [3:0] nib;
    logic [5:0] dps;
    if (!en) return 16'hFFFF;
    nib = 4'(v >> (4*idx));
    dps = dp >> idx;
    seg = seg_tbl[nib];
    seg[7] = ~dps[0];
`ifdef SEG_SCAN_LZB_EN
    if (idx != 0 && (v >> (4*idx)) == 24'd0) seg = dps[0] ? 8'h7F : 8'hFF;
`endif
    sel = ~(8'd1 << idx);
    return {sel, seg};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic take_word(input int stall, output logic [15:0] obs);
    int n;
    logic [15:0] exp;
    out_ready = (stall == 0);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("valid_wait", 16'(out_valid), 16'd1);
    if (m_idx == 0) begin
      s_val = lv_value;
      s_dp  = lv_dp;
      s_en  = lv_en;
    end
    exp = model(s_val, s_dp, s_en, m_idx);
    obs = out_word;
    chk("word", out_word, exp);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      if (stall >= SD) m_ovr = 1'b1;
      chk("word_hold", out_word, exp);
      out_ready = 1'b1;
    end
    #1;
    chk("frame_start", 16'(frame_start), 16'(m_idx == 0));
    chk("overrun", 16'(overrun), 16'(m_ovr));
    @(negedge clk);
    chk("valid_drop", 16'(out_valid), 16'd0);
    m_idx = (m_idx + 1) % ND;
  endtask

  logic [15:0] w;
  logic [15:0] t1 [6] = '{16'hFE8E, 16'hFDC0, 16'hFB83, 16'hF788, 16'hEFA4, 16'hDFF9};
  logic [15:0] t3 [3] = '{16'hEFA4, 16'hDFF9, 16'hFE92};
`ifdef SEG_SCAN_LZB_EN
  logic [15:0] t6 [6] = '{16'hFE92, 16'hFDC0, 16'hFBB0, 16'hF7FF, 16'hEFFF, 16'hDFFF};
  logic [15:0] t6dp   = 16'hEF7F;
`else
  logic [15:0] t6 [6] = '{16'hFE92, 16'hFDC0, 16'hFBB0, 16'hF7C0, 16'hEFC0, 16'hDFC0};
  logic [15:0] t6dp   = 16'hEF40;
`endif

  initial begin
    int n;
    rst = 1'b1;
    value = 24'h12AB0F;
    dp_mask = 6'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_word", out_word, 16'hFFFF);
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_frame", 16'(frame_start), 16'd0);
    chk("rst_ovr", 16'(overrun), 16'd0);
    rst = 1'b0;

    // steady scan, two frames
    for (int i = 0; i < 12; i++) begin
      take_word(0, w);
      chk("t1_seq", w, t1[i % 6]);
    end

    // new value mid-frame only lands at the next digit 0
    for (int i = 0; i < 4; i++) take_word(0, w);
    value = 24'h000005;
    for (int i = 0; i < 3; i++) begin
      take_word(0, w);
      chk("t3_snapshot", w, t3[i]);
    end
    for (int i = 0; i < 5; i++) take_word(0, w);

    // dark frame then restore
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      take_word(0, w);
      chk("t4_dark", w, 16'hFFFF);
    end
    enable = 1'b1;
    for (int i = 0; i < 6; i++) take_word(0, w);

    // leading-zero pattern
    value = 24'h000305;
    for (int i = 0; i < 6; i++) begin
      take_word(0, w);
      chk("t6_lzb", w, t6[i]);
    end
    dp_mask = 6'b010000;
    for (int i = 0; i < 6; i++) begin
      take_word(0, w);
      if (i == 4) chk("t6_dp", w, t6dp);
    end

    // long stall on digit 0 loses ticks
    value = 24'h12AB0F;
    dp_mask = 6'b0;
    take_word(20, w);
    chk("t2_stall_word", w, 16'hFE8E);
    take_word(0, w);
    chk("t2_next", w, 16'hFDC0);
    for (int i = 0; i < 4; i++) take_word(0, w);

    // randomized inputs and short stalls
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        value   = 24'($urandom);
        dp_mask = 6'($urandom);
        enable  = ($urandom_range(0, 3) != 0);
      end
      take_word($urandom_range(0, 3), w);
    end

    // asynchronous reset while a word is presented
    out_ready = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_pre_valid", 16'(out_valid), 16'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_valid_async", 16'(out_valid), 16'd0);
    chk("t5_word_async", out_word, 16'hFFFF);
    chk("t5_ovr_clr", 16'(overrun), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    value = 24'h9876C1;
    m_idx = 0;
    m_ovr = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t5_latency", 16'(n), 16'd9);
    for (int i = 0; i < 7; i++) take_word(0, w);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
